// File: rtl/pu_riscv_biu_arbiter.sv
// Shares one downstream BIU between the instruction and data memory controllers.
// Define PU_RISCV_BIU_ARB_RR_EN for round-robin arbitration; default is data priority with a starvation limit.
module pu_riscv_biu_arbiter #(
  parameter int XLEN            = 64,
  parameter int PLEN            = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            HCLK,
  input  logic            HRESET,

  input  logic            ibiu_stb_i,
  output logic            ibiu_stb_ack_o,
  output logic            ibiu_d_ack_o,
  input  logic [PLEN-1:0] ibiu_adri_i,
  output logic [PLEN-1:0] ibiu_adro_o,
  input  logic [2:0]      ibiu_size_i,
  input  logic [2:0]      ibiu_type_i,
  input  logic            ibiu_we_i,
  input  logic            ibiu_lock_i,
  input  logic [2:0]      ibiu_prot_i,
  input  logic [XLEN-1:0] ibiu_d_i,
  output logic [XLEN-1:0] ibiu_q_o,
  output logic            ibiu_ack_o,
  output logic            ibiu_err_o,

  input  logic            dbiu_stb_i,
  output logic            dbiu_stb_ack_o,
  output logic            dbiu_d_ack_o,
  input  logic [PLEN-1:0] dbiu_adri_i,
  output logic [PLEN-1:0] dbiu_adro_o,
  input  logic [2:0]      dbiu_size_i,
  input  logic [2:0]      dbiu_type_i,
  input  logic            dbiu_we_i,
  input  logic            dbiu_lock_i,
  input  logic [2:0]      dbiu_prot_i,
  input  logic [XLEN-1:0] dbiu_d_i,
  output logic [XLEN-1:0] dbiu_q_o,
  output logic            dbiu_ack_o,
  output logic            dbiu_err_o,

  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic            biu_we_o,
  output logic            biu_lock_o,
  output logic [2:0]      biu_prot_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,

  output logic [1:0]      gnt_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  // State encoding doubles as the gnt_o encoding
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          own_i_s, own_d_s, own_stb_s, own_lock_s;
  logic          accept_s, resp_s, dec_s, release_s, any_stb_s, win_d_s;

`ifdef PU_RISCV_BIU_ARB_RR_EN
  logic last_i_r, last_i_nxt_s;
`else
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] SCNT_MAX = SW'(STARVE_LIMIT);
  localparam bit STARVE_EN = (STARVE_LIMIT != 0);
  logic [SW-1:0] scnt_r, scnt_nxt_s;
  logic          starve_s;
`endif

  assign own_i_s   = (state_r == OWN_I);
  assign own_d_s   = (state_r == OWN_D);
  assign any_stb_s = ibiu_stb_i | dbiu_stb_i;

  // Owner's request fields go downstream; with no owner every request line is zero
  always_comb begin
    own_stb_s  = 1'b0;
    own_lock_s = 1'b0;
    biu_adri_o = {PLEN{1'b0}};
    biu_size_o = 3'b000;
    biu_type_o = 3'b000;
    biu_we_o   = 1'b0;
    biu_prot_o = 3'b000;
    biu_d_o    = {XLEN{1'b0}};
    case (state_r)
      OWN_I: begin
        own_stb_s  = ibiu_stb_i;
        own_lock_s = ibiu_lock_i;
        biu_adri_o = ibiu_adri_i;
        biu_size_o = ibiu_size_i;
        biu_type_o = ibiu_type_i;
        biu_we_o   = ibiu_we_i;
        biu_prot_o = ibiu_prot_i;
        biu_d_o    = ibiu_d_i;
      end
      OWN_D: begin
        own_stb_s  = dbiu_stb_i;
        own_lock_s = dbiu_lock_i;
        biu_adri_o = dbiu_adri_i;
        biu_size_o = dbiu_size_i;
        biu_type_o = dbiu_type_i;
        biu_we_o   = dbiu_we_i;
        biu_prot_o = dbiu_prot_i;
        biu_d_o    = dbiu_d_i;
      end
      default: begin
        own_stb_s  = 1'b0;
        own_lock_s = 1'b0;
      end
    endcase
  end

  assign biu_lock_o = own_lock_s;
  assign biu_stb_o  = own_stb_s & (cnt_r < CNT_MAX);
  assign accept_s   = biu_stb_o & biu_stb_ack_i;
  assign resp_s     = biu_ack_i | biu_err_i;
  // A response with nothing outstanding is stray and must not underflow cnt
  assign dec_s      = resp_s & (cnt_r != CNT_ZERO);

  assign ibiu_stb_ack_o = own_i_s & accept_s;
  assign dbiu_stb_ack_o = own_d_s & accept_s;
  assign ibiu_d_ack_o   = own_i_s & biu_d_ack_i;
  assign dbiu_d_ack_o   = own_d_s & biu_d_ack_i;
  assign ibiu_ack_o     = own_i_s & biu_ack_i;
  assign dbiu_ack_o     = own_d_s & biu_ack_i;
  assign ibiu_err_o     = own_i_s & biu_err_i;
  assign dbiu_err_o     = own_d_s & biu_err_i;
  assign ibiu_q_o       = biu_q_i;
  assign dbiu_q_o       = biu_q_i;
  assign ibiu_adro_o    = biu_adro_i;
  assign dbiu_adro_o    = biu_adro_i;
  assign gnt_o          = state_r;

  // Release once the owner is quiet, unlocked and its last beat is answered (IDLE always qualifies)
  assign release_s = ~own_stb_s & ~own_lock_s &
                     ((cnt_r == CNT_ZERO) | ((cnt_r == CNT_ONE) & resp_s));

`ifdef PU_RISCV_BIU_ARB_RR_EN
  assign win_d_s = dbiu_stb_i & ~(ibiu_stb_i & ~last_i_r);
`else
  assign starve_s = STARVE_EN & (scnt_r == SCNT_MAX);
  assign win_d_s  = dbiu_stb_i & ~(ibiu_stb_i & starve_s);
`endif

  // Outstanding-beat bookkeeping
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (accept_s && !dec_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec_s && !accept_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Grant decision and fairness tracking
  always_comb begin
    state_nxt_s = state_r;
`ifdef PU_RISCV_BIU_ARB_RR_EN
    last_i_nxt_s = last_i_r;
`else
    scnt_nxt_s = scnt_r;
`endif
    if (release_s && any_stb_s) begin
      state_nxt_s = win_d_s ? OWN_D : OWN_I;
`ifdef PU_RISCV_BIU_ARB_RR_EN
      last_i_nxt_s = ~win_d_s;
`else
      if (!win_d_s) begin
        scnt_nxt_s = {SW{1'b0}};
      end else if (!ibiu_stb_i) begin
        scnt_nxt_s = {SW{1'b0}};
      end else if (scnt_r != SCNT_MAX) begin
        scnt_nxt_s = scnt_r + SW'(1'b1);
      end else begin
        scnt_nxt_s = scnt_r;
      end
`endif
    end else if (release_s) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, outstanding-beat and fairness registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
`ifdef PU_RISCV_BIU_ARB_RR_EN
      last_i_r <= 1'b0;
`else
      scnt_r   <= {SW{1'b0}};
`endif
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
`ifdef PU_RISCV_BIU_ARB_RR_EN
      last_i_r <= last_i_nxt_s;
`else
      scnt_r   <= scnt_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Bench for pu_riscv_biu_arbiter: directed test-plan steps plus random traffic against a transaction-level model.
module tb_pu_riscv_biu_arbiter;

  localparam int MAX_OUT = 2;
  localparam int SL      = 2;
`ifdef PU_RISCV_BIU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [1:0] G_T1 = RR ? 2'b01 : 2'b10;
  localparam logic [1:0] G_T6 = RR ? 2'b01 : 2'b10;

  logic        clk = 1'b0, HRESET;
  logic        ibiu_stb_i, ibiu_stb_ack_o, ibiu_d_ack_o, ibiu_we_i, ibiu_lock_i, ibiu_ack_o, ibiu_err_o;
  logic [63:0] ibiu_adri_i, ibiu_adro_o, ibiu_d_i, ibiu_q_o;
  logic [2:0]  ibiu_size_i, ibiu_type_i, ibiu_prot_i;
  logic        dbiu_stb_i, dbiu_stb_ack_o, dbiu_d_ack_o, dbiu_we_i, dbiu_lock_i, dbiu_ack_o, dbiu_err_o;
  logic [63:0] dbiu_adri_i, dbiu_adro_o, dbiu_d_i, dbiu_q_o;
  logic [2:0]  dbiu_size_i, dbiu_type_i, dbiu_prot_i;
  logic        biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_we_o, biu_lock_o, biu_ack_i, biu_err_i;
  logic [63:0] biu_adri_o, biu_adro_i, biu_d_o, biu_q_i;
  logic [2:0]  biu_size_o, biu_type_o, biu_prot_o;
  logic [1:0]  gnt_o;

  int n_checks = 0, n_fail = 0;
  // model: owner 0 none / 1 instruction / 2 data, beats in flight, data-grant streak, last owner
  int m_owner, m_cnt, m_scnt, m_last;
  bit m_accept, m_resp;

  pu_riscv_biu_arbiter #(.XLEN(64), .PLEN(64), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(SL)) dut (
    .HCLK(clk), .HRESET(HRESET),
    .ibiu_stb_i(ibiu_stb_i), .ibiu_stb_ack_o(ibiu_stb_ack_o), .ibiu_d_ack_o(ibiu_d_ack_o),
    .ibiu_adri_i(ibiu_adri_i), .ibiu_adro_o(ibiu_adro_o), .ibiu_size_i(ibiu_size_i),
    .ibiu_type_i(ibiu_type_i), .ibiu_we_i(ibiu_we_i), .ibiu_lock_i(ibiu_lock_i),
    .ibiu_prot_i(ibiu_prot_i), .ibiu_d_i(ibiu_d_i), .ibiu_q_o(ibiu_q_o),
    .ibiu_ack_o(ibiu_ack_o), .ibiu_err_o(ibiu_err_o),
    .dbiu_stb_i(dbiu_stb_i), .dbiu_stb_ack_o(dbiu_stb_ack_o), .dbiu_d_ack_o(dbiu_d_ack_o),
    .dbiu_adri_i(dbiu_adri_i), .dbiu_adro_o(dbiu_adro_o), .dbiu_size_i(dbiu_size_i),
    .dbiu_type_i(dbiu_type_i), .dbiu_we_i(dbiu_we_i), .dbiu_lock_i(dbiu_lock_i),
    .dbiu_prot_i(dbiu_prot_i), .dbiu_d_i(dbiu_d_i), .dbiu_q_o(dbiu_q_o),
    .dbiu_ack_o(dbiu_ack_o), .dbiu_err_o(dbiu_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_we_o(biu_we_o), .biu_lock_o(biu_lock_o),
    .biu_prot_o(biu_prot_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i),
    .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ibiu_stb_i = 1'b0; dbiu_stb_i = 1'b0; ibiu_lock_i = 1'b0; dbiu_lock_i = 1'b0;
    ibiu_adri_i = 64'h1000; dbiu_adri_i = 64'h2000;
    ibiu_size_i = 3'd2; dbiu_size_i = 3'd3; ibiu_type_i = 3'd1; dbiu_type_i = 3'd5;
    ibiu_prot_i = 3'd4; dbiu_prot_i = 3'd6; ibiu_we_i = 1'b0; dbiu_we_i = 1'b1;
    ibiu_d_i = 64'hAAAA_0000_AAAA_0001; dbiu_d_i = 64'h5555_0000_5555_0002;
    biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
    biu_adro_i = 64'h0BAD_F00D; biu_q_i = 64'h1234_5678_9ABC_DEF0;
  endtask

  task automatic rand_inputs();
    ibiu_stb_i = ($urandom_range(0, 1) == 1); dbiu_stb_i = ($urandom_range(0, 1) == 1);
    ibiu_lock_i = ($urandom_range(0, 7) == 0); dbiu_lock_i = ($urandom_range(0, 7) == 0);
    ibiu_adri_i = {$urandom, $urandom}; dbiu_adri_i = {$urandom, $urandom};
    ibiu_d_i = {$urandom, $urandom}; dbiu_d_i = {$urandom, $urandom};
    ibiu_size_i = 3'($urandom); dbiu_size_i = 3'($urandom);
    ibiu_type_i = 3'($urandom); dbiu_type_i = 3'($urandom);
    ibiu_prot_i = 3'($urandom); dbiu_prot_i = 3'($urandom);
    ibiu_we_i = 1'($urandom); dbiu_we_i = 1'($urandom);
    biu_stb_ack_i = ($urandom_range(0, 1) == 1); biu_d_ack_i = ($urandom_range(0, 3) == 0);
    biu_ack_i = ($urandom_range(0, 2) == 0); biu_err_i = ($urandom_range(0, 19) == 0);
    biu_adro_i = {$urandom, $urandom}; biu_q_i = {$urandom, $urandom};
  endtask

  // Mid-cycle: compare every output against what the model says the bus should look like now
  task automatic sample();
    logic [63:0] e_adr, e_d;
    logic [2:0]  e_size, e_type, e_prot;
    logic        e_we, e_lock, e_stb;
    bit          i_own, d_own;
    @(negedge clk);
    i_own = (m_owner == 1);
    d_own = (m_owner == 2);
    e_adr = 64'd0; e_d = 64'd0; e_size = 3'd0; e_type = 3'd0; e_prot = 3'd0;
    e_we = 1'b0; e_lock = 1'b0; e_stb = 1'b0;
    if (i_own) begin
      e_adr = ibiu_adri_i; e_d = ibiu_d_i; e_size = ibiu_size_i; e_type = ibiu_type_i;
      e_prot = ibiu_prot_i; e_we = ibiu_we_i; e_lock = ibiu_lock_i; e_stb = ibiu_stb_i;
    end else if (d_own) begin
      e_adr = dbiu_adri_i; e_d = dbiu_d_i; e_size = dbiu_size_i; e_type = dbiu_type_i;
      e_prot = dbiu_prot_i; e_we = dbiu_we_i; e_lock = dbiu_lock_i; e_stb = dbiu_stb_i;
    end
    e_stb = e_stb && (m_cnt < MAX_OUT);
    m_accept = e_stb && biu_stb_ack_i;
    m_resp = biu_ack_i || biu_err_i;
    chk("gnt", 64'(gnt_o), 64'(m_owner));
    chk("biu_stb", 64'(biu_stb_o), 64'(e_stb));
    chk("biu_adri", biu_adri_o, e_adr);
    chk("biu_d", biu_d_o, e_d);
    chk("biu_fields", {51'd0, biu_size_o, biu_type_o, biu_prot_o, biu_we_o, biu_lock_o},
        {51'd0, e_size, e_type, e_prot, e_we, e_lock});
    chk("ibiu_stb_ack", 64'(ibiu_stb_ack_o), 64'(i_own && m_accept));
    chk("dbiu_stb_ack", 64'(dbiu_stb_ack_o), 64'(d_own && m_accept));
    chk("ibiu_d_ack", 64'(ibiu_d_ack_o), 64'(i_own && biu_d_ack_i));
    chk("dbiu_d_ack", 64'(dbiu_d_ack_o), 64'(d_own && biu_d_ack_i));
    chk("ibiu_ack", 64'(ibiu_ack_o), 64'(i_own && biu_ack_i));
    chk("dbiu_ack", 64'(dbiu_ack_o), 64'(d_own && biu_ack_i));
    chk("ibiu_err", 64'(ibiu_err_o), 64'(i_own && biu_err_i));
    chk("dbiu_err", 64'(dbiu_err_o), 64'(d_own && biu_err_i));
    chk("q_bcast", {ibiu_q_o ^ biu_q_i} | {dbiu_q_o ^ biu_q_i}, 64'd0);
    chk("adro_bcast", {ibiu_adro_o ^ biu_adro_i} | {dbiu_adro_o ^ biu_adro_i}, 64'd0);
  endtask

  // Clock edge: advance the transaction-level model with the inputs that were present
  task automatic advance();
    int  old;
    bit  pick_d, o_stb, o_lock;
    @(posedge clk);
    if (HRESET) begin
      m_owner = 0; m_cnt = 0; m_scnt = 0; m_last = 2;
    end else begin
      o_stb  = (m_owner == 1) ? ibiu_stb_i  : (m_owner == 2) ? dbiu_stb_i  : 1'b0;
      o_lock = (m_owner == 1) ? ibiu_lock_i : (m_owner == 2) ? dbiu_lock_i : 1'b0;
      old = m_cnt;
      m_cnt = old + (m_accept ? 1 : 0) - ((m_resp && old > 0) ? 1 : 0);
      if (m_owner == 0 || (!o_stb && !o_lock && m_cnt == 0)) begin
        if (ibiu_stb_i || dbiu_stb_i) begin
          if (ibiu_stb_i && dbiu_stb_i) begin
`ifdef PU_RISCV_BIU_ARB_RR_EN
            pick_d = (m_last == 1);
`else
            pick_d = !(SL != 0 && m_scnt == SL);
`endif
          end else begin
            pick_d = dbiu_stb_i;
          end
          if (pick_d) m_scnt = ibiu_stb_i ? ((m_scnt + 1 > SL) ? SL : m_scnt + 1) : 0;
          else m_scnt = 0;
          m_owner = pick_d ? 2 : 1;
          m_last  = m_owner;
        end else begin
          m_owner = 0;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    biu_ack_i = 1'b1;
    for (int c = 0; c < 8; c++) begin sample(); advance(); end
    biu_ack_i = 1'b0;
  endtask

  task automatic round(input logic [1:0] exp, input string tag);
    ibiu_stb_i = 1'b1; dbiu_stb_i = 1'b1; biu_stb_ack_i = 1'b1; biu_ack_i = 1'b0;
    sample(); advance();
    chk(tag, 64'(gnt_o), 64'(exp));
    sample(); advance();
    ibiu_stb_i = 1'b0; dbiu_stb_i = 1'b0; biu_ack_i = 1'b1;
    sample(); advance();
    chk({tag, "_released"}, 64'(gnt_o), 64'd0);
    biu_ack_i = 1'b0;
  endtask

  initial begin
    logic [1:0] pipe;
    int  nacc, nack;
    bit  done;
    m_owner = 0; m_cnt = 0; m_scnt = 0; m_last = 2;
    clear_inputs();
    HRESET = 1'b1;
    sample(); advance();
    HRESET = 1'b0;
    sample(); advance();
    chk("reset_gnt", 64'(gnt_o), 64'd0);

    // 1: simultaneous requests
    ibiu_stb_i = 1'b1; dbiu_stb_i = 1'b1;
    sample(); chk("t1_istb_ack_c0", 64'(ibiu_stb_ack_o), 64'd0); advance();
    chk("t1_gnt", 64'(gnt_o), 64'(G_T1));
    sample();
    chk("t1_adri", biu_adri_o, RR ? 64'h1000 : 64'h2000);
    chk("t1_istb_ack_c1", 64'(ibiu_stb_ack_o), 64'd0);
    advance();
    ibiu_stb_i = 1'b0; dbiu_stb_i = 1'b0;
    sample(); advance();

    // 2: data burst of 4, responses two cycles after acceptance, instruction waiting
    ibiu_stb_i = 1'b1; dbiu_stb_i = 1'b1; biu_stb_ack_i = 1'b1;
    pipe = 2'b00; nacc = 0; nack = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      biu_ack_i = pipe[1];
      sample();
      if (m_owner == 2 && dbiu_stb_i && m_cnt == MAX_OUT) chk("t2_masked", 64'(biu_stb_o), 64'd0);
      if (m_owner == 2 && m_accept) nacc++;
      if (m_owner == 2 && biu_ack_i && m_cnt > 0) nack++;
      advance();
      pipe = {pipe[0], m_accept};
      if (nacc == 4) dbiu_stb_i = 1'b0;
      if (nack == 4) begin
        chk("t2_handoff", 64'(gnt_o), 64'b01);
        done = 1'b1;
      end
    end
    chk("t2_completed", 64'(done), 64'd1);
    drain();

    // 3: locked data sequence holds the grant
    dbiu_stb_i = 1'b1; dbiu_lock_i = 1'b1;
    sample(); advance();
    chk("t3_gnt", 64'(gnt_o), 64'b10);
    dbiu_stb_i = 1'b0; ibiu_stb_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample(); advance();
      chk("t3_locked", 64'(gnt_o), 64'b10);
    end
    dbiu_lock_i = 1'b0;
    sample(); advance();
    chk("t3_release", 64'(gnt_o), 64'b01);
    ibiu_stb_i = 1'b0;
    sample(); advance();

    // 4: repeated contention
    round(2'b10, "t4_r1");
    round(RR ? 2'b01 : 2'b10, "t4_r2");
    round(RR ? 2'b10 : 2'b01, "t4_r3");
    round(RR ? 2'b01 : 2'b10, "t4_r4");

    // 5: error beat for instruction owner, then a stray ack while idle
    ibiu_stb_i = 1'b1; biu_stb_ack_i = 1'b1;
    sample(); advance();
    sample(); advance();
    ibiu_stb_i = 1'b0; biu_stb_ack_i = 1'b0; biu_err_i = 1'b1;
    sample();
    chk("t5_ierr", 64'(ibiu_err_o), 64'd1);
    chk("t5_derr", 64'(dbiu_err_o), 64'd0);
    advance();
    chk("t5_released", 64'(gnt_o), 64'd0);
    biu_err_i = 1'b0; biu_ack_i = 1'b1;
    sample();
    chk("t5_stray_iack", 64'(ibiu_ack_o), 64'd0);
    chk("t5_stray_dack", 64'(dbiu_ack_o), 64'd0);
    advance();
    biu_ack_i = 1'b0;

    // 6: reset with the outstanding window full
    dbiu_stb_i = 1'b1; biu_stb_ack_i = 1'b1;
    for (int c = 0; c < 4; c++) begin sample(); advance(); end
    ibiu_stb_i = 1'b1; biu_ack_i = 1'b1; HRESET = 1'b1;
    sample(); advance();
    HRESET = 1'b0;
    sample();
    chk("t6_gnt", 64'(gnt_o), 64'd0);
    chk("t6_stb", 64'(biu_stb_o), 64'd0);
    chk("t6_acks", {60'd0, ibiu_stb_ack_o, dbiu_stb_ack_o, ibiu_ack_o, dbiu_ack_o}, 64'd0);
    advance();
    chk("t6_first_contention", 64'(gnt_o), 64'(G_T6));
    drain();

    // random traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      HRESET = ($urandom_range(0, 299) == 0);
      sample(); advance();
    end
    HRESET = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
